// File: rtl/vc_grant_tracker.sv
// rtl/vc_grant_tracker.sv - per-VC grant reservation and credit tracker
// Accepts one-hot grants, holds VCs busy until tail, tracks downstream credits.
module vc_grant_tracker #(
  parameter int NUM_VC  = 4,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3,
  parameter int IDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grant_valid,
  input  logic [NUM_VC-1:0] grant_in,
  output logic [NUM_VC-1:0] vc_avail,
  output logic              sel_valid,
  output logic [IDX_W-1:0]  sel_vc,
  input  logic              flit_sent,
  input  logic [IDX_W-1:0]  flit_vc,
  input  logic              flit_tail,
  input  logic [NUM_VC-1:0] credit_in,
  output logic              err
);

  logic [NUM_VC-1:0] reserved_q, reserved_d;
  logic [CNT_W-1:0]  cred_q [NUM_VC];
  logic [CNT_W-1:0]  cred_d [NUM_VC];
  logic              sel_valid_q, sel_valid_d;
  logic [IDX_W-1:0]  sel_vc_q, sel_vc_d;
  logic              err_q, err_d;

  logic              grant_onehot;
  logic [IDX_W-1:0]  grant_idx;
  logic              accept;
  logic              send_hit, send_res, send_has_cred, send_ok;
  logic              ovf_any;

  always_comb begin
    for (int j = 0; j < NUM_VC; j++) begin
      vc_avail[j] = ~reserved_q[j] & (cred_q[j] != '0);
    end
  end

  assign grant_onehot = (grant_in != '0) &&
                        ((grant_in & (grant_in - NUM_VC'(1))) == '0);

  always_comb begin
    grant_idx = '0;
    for (int j = 0; j < NUM_VC; j++) begin
      if (grant_in[j]) grant_idx = IDX_W'(j);
    end
  end

  assign accept = grant_valid & grant_onehot & ((grant_in & vc_avail) != '0);

  // An out-of-range flit_vc matches no VC, so it falls out as an illegal send.
  always_comb begin
    send_hit      = 1'b0;
    send_res      = 1'b0;
    send_has_cred = 1'b0;
    for (int j = 0; j < NUM_VC; j++) begin
      if (flit_vc == IDX_W'(j)) begin
        send_hit      = 1'b1;
        send_res      = reserved_q[j];
        send_has_cred = (cred_q[j] != '0);
      end
    end
  end

  assign send_ok = flit_sent & send_hit & send_res & send_has_cred;

  always_comb begin
    reserved_d  = reserved_q;
    ovf_any     = 1'b0;
    for (int j = 0; j < NUM_VC; j++) begin
      logic inc, dec;
      dec = send_ok && (flit_vc == IDX_W'(j));
      inc = credit_in[j] && (cred_q[j] != CNT_W'(CREDITS));
      if (credit_in[j] && (cred_q[j] == CNT_W'(CREDITS))) ovf_any = 1'b1;
      cred_d[j] = cred_q[j] + CNT_W'(inc) - CNT_W'(dec);
      if (dec && flit_tail) reserved_d[j] = 1'b0;
      if (accept && grant_in[j]) reserved_d[j] = 1'b1;
    end
    sel_valid_d = accept;
    sel_vc_d    = accept ? grant_idx : sel_vc_q;
    err_d       = (grant_valid & ~accept) | (flit_sent & ~send_ok) | ovf_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reserved_q  <= '0;
      for (int j = 0; j < NUM_VC; j++) cred_q[j] <= CNT_W'(CREDITS);
      sel_valid_q <= 1'b0;
      sel_vc_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      reserved_q  <= reserved_d;
      for (int j = 0; j < NUM_VC; j++) cred_q[j] <= cred_d[j];
      sel_valid_q <= sel_valid_d;
      sel_vc_q    <= sel_vc_d;
      err_q       <= err_d;
    end
  end

  assign sel_valid = sel_valid_q;
  assign sel_vc    = sel_vc_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vc_grant_tracker.sv
// tb/tb_vc_grant_tracker.sv - directed self-checking bench for vc_grant_tracker
module tb_vc_grant_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       grant_valid;
  logic [3:0] grant_in;
  logic [3:0] vc_avail;
  logic       sel_valid;
  logic [1:0] sel_vc;
  logic       flit_sent;
  logic [1:0] flit_vc;
  logic       flit_tail;
  logic [3:0] credit_in;
  logic       err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vc_grant_tracker #(.NUM_VC(4), .CREDITS(4), .CNT_W(3), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .grant_valid(grant_valid), .grant_in(grant_in),
    .vc_avail(vc_avail), .sel_valid(sel_valid), .sel_vc(sel_vc),
    .flit_sent(flit_sent), .flit_vc(flit_vc), .flit_tail(flit_tail),
    .credit_in(credit_in), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    grant_valid = 1'b0;
    grant_in    = '0;
    flit_sent   = 1'b0;
    flit_tail   = 1'b0;
    flit_vc     = '0;
    credit_in   = '0;
  endtask

  task automatic send(input logic [1:0] vc, input logic tail);
    flit_sent = 1'b1;
    flit_vc   = vc;
    flit_tail = tail;
  endtask

  task automatic grant(input logic [3:0] g);
    grant_valid = 1'b1;
    grant_in    = g;
  endtask

  initial begin
    rst_n = 1'b0;
    grant_valid = 0; grant_in = 0; flit_sent = 0; flit_vc = 0; flit_tail = 0; credit_in = 0;
    tick(); tick();
    chk("rst_avail", vc_avail, 4'b1111);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_sel_vc", sel_vc, 0);
    for (int j = 0; j < 4; j++) chk($sformatf("rst_cred%0d", j), dut.cred_q[j], 4);
    rst_n = 1'b1;
    tick();

    grant(4'b0100); tick();
    chk("g2_sel_valid", sel_valid, 1);
    chk("g2_sel_vc", sel_vc, 2);
    chk("g2_avail", vc_avail, 4'b1011);
    chk("g2_err", err, 0);
    tick();
    chk("g2_pulse", sel_valid, 0);
    chk("g2_sel_vc_hold", sel_vc, 2);
    send(2, 0); tick();
    send(2, 0); tick();
    send(2, 1); tick();
    chk("vc2_cred1", dut.cred_q[2], 1);
    chk("vc2_avail_after_tail", vc_avail, 4'b1111);
    chk("vc2_tail_err", err, 0);
    credit_in = 4'b0100; tick();
    chk("vc2_cred2", dut.cred_q[2], 2);

    grant(4'b0010); tick();
    chk("g1_sel_vc", sel_vc, 1);
    chk("g1_avail", vc_avail, 4'b1101);
    for (int k = 0; k < 4; k++) begin
      send(1, 0); tick();
      chk("vc1_send_err", err, 0);
    end
    chk("vc1_cred0", dut.cred_q[1], 0);
    send(1, 0); tick();
    chk("vc1_empty_err", err, 1);
    chk("vc1_cred_stays0", dut.cred_q[1], 0);
    send(1, 1); tick();
    chk("vc1_tail_nocred_err", err, 1);
    chk("vc1_still_res", dut.reserved_q[1], 1);
    credit_in = 4'b0010; tick();
    chk("vc1_cred1_avail", vc_avail, 4'b1101);
    send(1, 1); tick();
    chk("vc1_tail_err", err, 0);
    chk("vc1_free", dut.reserved_q[1], 0);
    chk("vc1_avail_nocred", vc_avail, 4'b1101);
    credit_in = 4'b0010; tick();
    chk("vc1_avail_back", vc_avail, 4'b1111);

    grant(4'b0110); tick();
    chk("multi_err", err, 1);
    chk("multi_sel_valid", sel_valid, 0);
    chk("multi_avail", vc_avail, 4'b1111);
    grant(4'b0000); tick();
    chk("zero_err", err, 1);
    chk("zero_sel_valid", sel_valid, 0);
    grant_in = 4'b0100; tick();
    chk("novalid_err", err, 0);
    chk("novalid_sel_valid", sel_valid, 0);
    chk("novalid_avail", vc_avail, 4'b1111);

    grant(4'b1000); tick();
    chk("g3_sel_vc", sel_vc, 3);
    chk("g3_avail", vc_avail, 4'b0111);
    send(3, 1); grant(4'b1000); tick();
    chk("same_vc_err", err, 1);
    chk("same_vc_sel_valid", sel_valid, 0);
    chk("same_vc_free", vc_avail, 4'b1111);
    grant(4'b1000); tick();
    chk("g3b_sel_valid", sel_valid, 1);
    send(3, 1); grant(4'b0001); tick();
    chk("cross_sel_valid", sel_valid, 1);
    chk("cross_sel_vc", sel_vc, 0);
    chk("cross_err", err, 0);
    chk("cross_avail", vc_avail, 4'b1110);
    chk("cross_cred3", dut.cred_q[3], 2);

    credit_in = 4'b0001; tick();
    chk("ovf_err", err, 1);
    chk("ovf_cred0", dut.cred_q[0], 4);
    tick();
    chk("ovf_pulse", err, 0);

    send(0, 0); tick();
    send(0, 0); credit_in = 4'b0001; tick();
    chk("incdec_cred0", dut.cred_q[0], 3);
    chk("incdec_err", err, 0);

    grant(4'b0100); tick();
    chk("pre_rst_avail", vc_avail, 4'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_avail", vc_avail, 4'b1111);
    chk("async_rst_sel_valid", sel_valid, 0);
    chk("async_rst_cred0", dut.cred_q[0], 4);
    chk("async_rst_cred3", dut.cred_q[3], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vc_grant_tracker.md
Name: vc_grant_tracker

Overview:
- Consumer end of the per-VC fixed-priority grant interface, one instance per output port per VN.
- Receives the one-hot grant vector that the priority selector produces and encodes it to a registered VC index.
- Reserves the granted VC until its tail flit releases it, and keeps a per-VC downstream credit count.
- Drives back the per-VC availability vector that feeds the selector's request input, closing the request/grant loop.

Parameters:
NUM_VC, 4, virtual channels per VN; 1..16.
CREDITS, 4, reset credit count per VC (downstream buffer depth in flits); at least 1.
CNT_W, 3, credit counter width; 2^CNT_W must be greater than CREDITS.
IDX_W, 2, VC index width, equal to max(1, clog2(NUM_VC)).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
grant_valid  in  1  grant_in is valid this cycle.
grant_in  in  NUM_VC  one-hot grant vector from the fixed-priority selector.
vc_avail  out  NUM_VC  per-VC available flags; feeds the selector's request input.
sel_valid  out  1  one-cycle pulse: a grant was accepted.
sel_vc  out  IDX_W  binary index of the accepted VC; held until the next accept.
flit_sent  in  1  a flit left on the VC given by flit_vc.
flit_vc  in  IDX_W  VC index of the sent flit.
flit_tail  in  1  the sent flit is a tail; releases flit_vc.
credit_in  in  NUM_VC  per-VC credit-return pulses from downstream.
err  out  1  one-cycle pulse on any protocol violation.

Behaviour:
- State per VC j: reserved[j] (1 bit) and cred[j] (CNT_W bits), where reserved[j]=1 means BUSY and 0 means FREE.
- Reset (async assert, sync-free deassert): reserved=0, cred=CREDITS, sel_valid=0, sel_vc=0, err=0; vc_avail therefore reads all-ones.
- vc_avail[j] = ~reserved[j] & (cred[j] != 0). Combinational from registers only; no path from any input.
- Grant acceptance, evaluated on registered state at the clock edge:
  - Accepted when grant_valid=1, grant_in has exactly one bit set (bit j), and vc_avail[j]=1.
  - Next cycle: reserved[j]=1, sel_valid=1, sel_vc=j. Latency is 1 cycle.
- Grant rejection: grant_valid=1 with zero bits set, more than one bit set, or bit j with vc_avail[j]=0. No state change; err=1 next cycle.
- Grant is ignored entirely when grant_valid=0.
- Flit send:
  - flit_sent=1 decrements cred[flit_vc].
  - Error, next cycle err=1, with no decrement and no release, when: flit_vc >= NUM_VC, reserved[flit_vc]=0, or cred[flit_vc]=0.
  - flit_tail=1 on a legal send clears reserved[flit_vc] next cycle.
- Credit return: credit_in[j]=1 increments cred[j]. When cred[j] is already CREDITS the count holds and err=1.
- Simultaneous events on one VC, same edge:
  - Decrement and increment together: count unchanged.
  - Tail release and a new grant on the same VC: the grant sees the old reserved=1, so it is rejected with err=1; the VC ends FREE.
  - A grant to VC a together with a tail release of VC b (a != b): both take effect.
- Error pulse: err is the OR of all violations in the cycle. Multiple simultaneous violations still produce a single pulse.
- sel_valid is a pulse, never held high across two cycles unless accepts occur back to back.
- Reset asserted mid-packet: all VCs return FREE with full credits immediately. There is no drain.

Test Plan:
1. Reset with NUM_VC=4, CREDITS=4 -> vc_avail=4'b1111, sel_valid=0, err=0, all cred=4.
2. grant_valid=1, grant_in=4'b0100 -> next cycle sel_valid=1, sel_vc=2, vc_avail=4'b1011. Then 3 flit_sent on VC2 with the last one tail -> cred[2]=1 and vc_avail=4'b1111 after the tail. One credit_in[2] pulse -> cred[2]=2.
3. Send 4 non-tail flits on reserved VC1 with no credit return -> cred[1]=0. A fifth send -> err pulse, cred stays 0. Tail release -> vc_avail[1] stays 0 until one credit_in[1] pulse, then becomes 1.
4. grant_in=4'b0110 -> err=1, no sel_valid, vc_avail unchanged. grant_in=4'b0000 with grant_valid=1 -> err=1.
5. VC3 reserved; same cycle tail on VC3 and grant_in=4'b1000 -> err=1, sel_valid=0, VC3 FREE afterwards. Same cycle tail on VC3 and grant 4'b0001 -> sel_vc=0 and VC3 FREE.
6. credit_in[0] at cred=4 -> err=1 and cred holds at 4. Assert rst_n low with VCs 0 and 2 reserved -> vc_avail=4'b1111 immediately, with no clock edge needed.
